// File: rtl/axi_tensor_rd_burst.sv
// AXI4 read master: splits one tensor transfer into page-safe INCR bursts and
// streams the returned beats through a fall-through FIFO with index/last/err.
module axi_tensor_rd_burst #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 256,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH      = 32,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_beats,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_dat,
  output logic [LEN_WIDTH-1:0]  m_idx,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  done,
  output logic                  err
);
  localparam int BYTES_LOG = $clog2(DATA_WIDTH / 8);
  localparam int FA        = $clog2(FIFO_DEPTH);
  localparam int OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    remaining;
  logic [LEN_WIDTH-1:0]    total_q;
  logic [LEN_WIDTH-1:0]    idx_q;
  logic [8:0]              len_q;
  logic [8:0]              next_len;
  logic [OW-1:0]           outstanding;
  logic                    ar_hs, r_hs, r_last_hs, push, pop;
  logic [FA:0]             count;
  logic [FA-1:0]           wr_ptr, rd_ptr;
  logic                    fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic                    unused_rid;

  // Beats allowed in the next burst: bounded by what is left, the burst cap
  // and the distance to the next 4 KB page boundary.
  function automatic logic [8:0] burst_len(input logic [LEN_WIDTH-1:0] rem,
                                           input logic [11:0] page_off);
    int unsigned lim;
    int unsigned page_beats;
    page_beats = (32'd4096 - {20'd0, page_off}) >> BYTES_LOG;
    lim = MAX_BURST;
    if (32'(rem) < lim) lim = 32'(rem);
    if (page_beats < lim) lim = page_beats;
    return 9'(lim);
  endfunction

  assign unused_rid    = ^m_axi_rid;
  assign next_len      = burst_len(remaining, addr_q[11:0]);
  assign ar_hs         = m_axi_arvalid && m_axi_arready;
  assign r_hs          = m_axi_rvalid && m_axi_rready;
  assign r_last_hs     = r_hs && m_axi_rlast;
  assign fifo_full     = (count == (FA+1)'(FIFO_DEPTH));
  assign fifo_empty    = (count == '0);
  assign push          = r_hs;
  assign pop           = m_valid && m_ready;

  assign m_axi_arid    = '0;
  assign m_axi_arsize  = 3'(BYTES_LOG);
  assign m_axi_arburst = 2'b01;
  assign m_axi_rready  = (state != S_IDLE) && !fifo_full;
  assign m_valid       = !fifo_empty;
  assign m_dat         = mem[rd_ptr];
  assign m_idx         = idx_q;
  assign m_last        = m_valid && (idx_q == total_q - LEN_WIDTH'(1));

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= m_axi_rdata;
  end

  // Full is derived from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FA'(1);
      if (pop)  rd_ptr <= rd_ptr + FA'(1);
      count <= count + (FA+1)'(push) - (FA+1)'(pop);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      cmd_ready     <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      addr_q        <= '0;
      remaining     <= '0;
      total_q       <= '0;
      idx_q         <= '0;
      len_q         <= '0;
      outstanding   <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done        <= 1'b0;
      outstanding <= outstanding + OW'(ar_hs) - OW'(r_last_hs);
      if (push && m_axi_rresp != 2'b00) err <= 1'b1;
      if (pop) idx_q <= idx_q + LEN_WIDTH'(1);
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            addr_q    <= cmd_addr & ALIGN_MASK;
            remaining <= cmd_beats;
            total_q   <= cmd_beats;
            idx_q     <= '0;
            err       <= 1'b0;
            if (cmd_beats == '0) begin
              done <= 1'b1;
            end else begin
              state     <= S_ISSUE;
              cmd_ready <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          if (m_axi_arvalid) begin
            if (m_axi_arready) begin
              m_axi_arvalid <= 1'b0;
              addr_q        <= addr_q + (ADDR_WIDTH'(len_q) << BYTES_LOG);
              remaining     <= remaining - LEN_WIDTH'(len_q);
              if (remaining == LEN_WIDTH'(len_q)) state <= S_DRAIN;
            end
          end else if (remaining != '0 && outstanding < OW'(MAX_OUTSTANDING)) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= addr_q;
            m_axi_arlen   <= 8'(next_len - 9'd1);
            len_q         <= next_len;
          end
        end
        S_DRAIN: begin
          if (outstanding == '0 && fifo_empty && idx_q == total_q) begin
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_tensor_rd_burst.sv
// Bench for axi_tensor_rd_burst: randomized AXI slave and stream sink checked
// against a transfer-level model of burst splitting and beat delivery.
module tb_axi_tensor_rd_burst;
  localparam int AW = 32, DW = 256, IW = 4, LW = 16, MB = 16, MO = 4, FD = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_beats;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid, m_axi_arready;
  logic [IW-1:0] m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] m_dat;
  logic [LW-1:0] m_idx;
  logic          m_last, m_valid, m_ready, done, err;

  axi_tensor_rd_burst #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(MB),
    .MAX_OUTSTANDING(MO), .FIFO_DEPTH(FD), .LEN_WIDTH(LW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_dat(m_dat), .m_idx(m_idx), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .done(done), .err(err)
  );

  initial forever #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  len;
  } ar_t;

  ar_t           exp_ar[$];
  int            burst_q[$];
  logic [DW-1:0] exp_dat[$];
  int  checks = 0, errors = 0;
  int  total, pop_cnt, r_acc, ar_cnt, ar_total, r_beat;
  int  last_pop_cyc, first_rlast_cyc, ar5_cyc;
  bit  err_model;
  int  ar_mode = 0, r_mode = 1, s_mode = 1, err_beat = -1, err_rate = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Transfer-level model: the list of bursts a command must produce.
  task automatic plan(input logic [31:0] addr, input int beats);
    logic [31:0] a;
    int rem, len, page;
    a = addr & ~32'd31;
    rem = beats;
    exp_ar.delete();
    while (rem > 0) begin
      page = (4096 - int'(a % 32'd4096)) / 32;
      len = rem;
      if (len > MB) len = MB;
      if (page < len) len = page;
      exp_ar.push_back('{a: a, len: 8'(len - 1)});
      a += 32'(len * 32);
      rem -= len;
    end
    ar_total = exp_ar.size();
  endtask

  task automatic flush_model();
    exp_ar.delete(); burst_q.delete(); exp_dat.delete();
    pop_cnt = 0; r_acc = 0; ar_cnt = 0; r_beat = 0; err_model = 0;
    first_rlast_cyc = -1; ar5_cyc = -1; last_pop_cyc = -1;
  endtask

  // AR channel slave.
  initial begin
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    bit          pending;
    ar_t         e;
    m_axi_arready = 1'b0;
    pending = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        m_axi_arready = 1'b0;
        pending = 0;
        continue;
      end
      if (pending) begin
        chk("ar_valid_held", 256'(m_axi_arvalid), 256'(1));
        chk("ar_addr_stable", 256'(m_axi_araddr), 256'(prev_addr));
        chk("ar_len_stable", 256'(m_axi_arlen), 256'(prev_len));
      end
      m_axi_arready = (ar_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      pending   = m_axi_arvalid && !m_axi_arready;
      prev_addr = m_axi_araddr;
      prev_len  = m_axi_arlen;
      if (m_axi_arvalid && m_axi_arready) begin
        ar_cnt++;
        if (ar_cnt == 5) ar5_cyc = cyc;
        if (exp_ar.size() == 0) begin
          chk("ar_count_extra", 256'(ar_cnt), 256'(ar_total));
        end else begin
          e = exp_ar.pop_front();
          chk("araddr", 256'(m_axi_araddr), 256'(e.a));
          chk("arlen", 256'(m_axi_arlen), 256'(e.len));
          chk("arsize", 256'(m_axi_arsize), 256'(5));
          chk("arburst_arid", 256'({m_axi_arburst, m_axi_arid}), 256'({2'b01, 4'd0}));
        end
        burst_q.push_back(int'(m_axi_arlen) + 1);
      end
    end
  end

  // R channel slave: serves bursts in AR order, holds a beat until accepted.
  initial begin
    int left;
    bit holding, err_seen, go;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rid = '0;
    left = 0; holding = 0; err_seen = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        left = 0; holding = 0; err_seen = 0;
        continue;
      end
      if (err_seen) chk("err_after_bad_beat", 256'(err), 256'(1));
      err_seen = 0;
      if (!holding) begin
        if (left == 0 && burst_q.size() > 0 && r_mode != 0) left = burst_q.pop_front();
        go = (left > 0) && (r_mode == 1 || (r_mode == 2 && $urandom_range(0, 3) != 0));
        m_axi_rvalid = go;
        m_axi_rlast  = go && (left == 1);
        m_axi_rdata  = {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()};
        m_axi_rresp  = ((r_beat == err_beat) ||
                        (err_rate > 0 && $urandom_range(0, 99) < err_rate)) ? 2'b10 : 2'b00;
      end
      holding = m_axi_rvalid && !m_axi_rready;
      if (m_axi_rvalid && m_axi_rready) begin
        r_acc++;
        exp_dat.push_back(m_axi_rdata);
        if (m_axi_rresp != 2'b00) begin
          err_model = 1;
          err_seen = 1;
        end
        if (m_axi_rlast && first_rlast_cyc < 0) first_rlast_cyc = cyc;
        left--;
        r_beat++;
      end
    end
  end

  // Stream sink: every pop must match the next accepted R beat, in order.
  initial begin
    logic [DW-1:0] d;
    m_ready = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        m_ready = 1'b0;
        continue;
      end
      m_ready = (s_mode == 1) || (s_mode == 2 && $urandom_range(0, 1) == 1);
      if (m_valid && m_ready) begin
        if (exp_dat.size() == 0) begin
          chk("stream_pops_vs_beats", 256'(pop_cnt + 1), 256'(r_acc));
        end else begin
          d = exp_dat.pop_front();
          chk("m_dat", m_dat, d);
        end
        chk("m_idx", 256'(m_idx), 256'(pop_cnt));
        chk("m_last", 256'(m_last), 256'(pop_cnt == total - 1));
        pop_cnt++;
        last_pop_cyc = cyc;
      end
    end
  end

  task automatic start_cmd(input logic [31:0] addr, input int beats);
    chk("cmd_ready_idle", 256'(cmd_ready), 256'(1));
    flush_model();
    plan(addr, beats);
    total = beats;
    cmd_addr = addr;
    cmd_beats = LW'(beats);
    cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    chk("err_clear_on_accept", 256'(err), 256'(0));
    chk("done_after_accept", 256'(done), 256'(beats == 0));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 4000) begin
      @(negedge aclk);
      n++;
    end
    chk($sformatf("%s_done_seen", tag), 256'(done), 256'(1));
    if (done) begin
      chk($sformatf("%s_beats", tag), 256'(pop_cnt), 256'(total));
      chk($sformatf("%s_ar_count", tag), 256'(ar_cnt), 256'(ar_total));
      chk($sformatf("%s_done_latency", tag), 256'(cyc), 256'(last_pop_cyc + 2));
      chk($sformatf("%s_err", tag), 256'(err), 256'(err_model));
      @(negedge aclk);
      chk($sformatf("%s_done_pulse", tag), 256'(done), 256'(0));
      chk($sformatf("%s_cmd_ready", tag), 256'(cmd_ready), 256'(1));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk($sformatf("%s_cmd_ready", tag), 256'(cmd_ready), 256'(0));
    chk($sformatf("%s_arvalid", tag), 256'(m_axi_arvalid), 256'(0));
    chk($sformatf("%s_rready", tag), 256'(m_axi_rready), 256'(0));
    chk($sformatf("%s_m_valid", tag), 256'(m_valid), 256'(0));
    chk($sformatf("%s_done_err", tag), 256'({done, err}), 256'(0));
  endtask

  initial begin
    int n;
    logic [31:0] ra;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    total = 0;
    flush_model();
    repeat (3) @(negedge aclk);
    chk_reset_outputs("reset");
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    chk("idle_cmd_ready", 256'(cmd_ready), 256'(1));
    chk("idle_m_idx", 256'(m_idx), 256'(0));

    // Three-burst transfer.
    ar_mode = 0; r_mode = 1; s_mode = 1;
    start_cmd(32'h1000, 40);
    wait_done("basic40");
    chk("basic40_three_ars", 256'(ar_cnt), 256'(3));

    // 4 KB boundary split.
    ar_mode = 1; r_mode = 2; s_mode = 2;
    start_cmd(32'h1F80, 8);
    wait_done("page4k");
    chk("page4k_two_ars", 256'(ar_cnt), 256'(2));

    // Outstanding limit: no R data until released.
    ar_mode = 0; r_mode = 0; s_mode = 1;
    start_cmd(32'h0, 96);
    n = 0;
    while (ar_cnt < 4 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    repeat (20) @(negedge aclk);
    chk("outst_ar_cnt", 256'(ar_cnt), 256'(4));
    chk("outst_arvalid_low", 256'(m_axi_arvalid), 256'(0));
    r_mode = 1;
    wait_done("outst");
    chk("outst_5th_after_rlast", 256'(ar5_cyc > first_rlast_cyc), 256'(1));

    // Stream backpressure fills the FIFO.
    ar_mode = 0; r_mode = 1; s_mode = 0;
    start_cmd(32'h1000, 40);
    repeat (150) @(negedge aclk);
    chk("bp_beats_accepted", 256'(r_acc), 256'(FD));
    chk("bp_rready_low", 256'(m_axi_rready), 256'(0));
    chk("bp_m_valid", 256'(m_valid), 256'(1));
    s_mode = 1;
    wait_done("bp");

    // Error response on beat 5, sticky until next accept.
    ar_mode = 1; r_mode = 2; s_mode = 2; err_beat = 5;
    start_cmd(32'h400, 16);
    wait_done("rresp_err");
    repeat (5) @(negedge aclk);
    chk("err_sticky", 256'(err), 256'(1));
    err_beat = -1;

    // Zero-beat command.
    start_cmd(32'h40, 0);
    repeat (10) @(negedge aclk);
    chk("zero_no_ar", 256'(ar_cnt), 256'(0));
    chk("zero_cmd_ready", 256'(cmd_ready), 256'(1));

    // Asynchronous reset mid-transfer, then a fresh command.
    ar_mode = 1; r_mode = 2; s_mode = 2;
    start_cmd(32'h3000, 64);
    repeat (25) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(negedge aclk);
    flush_model();
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    start_cmd(32'h3000, 20);
    wait_done("post_reset");

    // Randomized commands.
    ar_mode = 1; r_mode = 2; s_mode = 2; err_rate = 5;
    for (int i = 0; i < 6; i++) begin
      ra = 32'($urandom_range(0, 1023)) * 32 + 32'($urandom_range(0, 31));
      start_cmd(ra, int'($urandom_range(1, 70)));
      wait_done($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_tensor_rd_burst.md
Name: axi_tensor_rd_burst

Overview:
Next-generation AXI4 read master for the tensor core. It accepts one transfer command of arbitrary length (address plus beat count) and splits it into INCR bursts. Each burst is capped by MAX_BURST and never crosses a 4 KB page. Up to MAX_OUTSTANDING AR requests may be in flight at once. Read data passes through an internal FIFO to the compute-core stream, with a per-transfer beat index, a last flag, a sticky error flag and a completion pulse.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 256, beat width in bits; power of 2, 32..1024
ID_WIDTH, 4, AXI ID width; all ARs use ID 0
MAX_BURST, 16, max beats per burst; power of 2, 2..256
MAX_OUTSTANDING, 4, max issued-but-not-completed bursts (rlast not yet received)
FIFO_DEPTH, 32, read-data FIFO entries; power of 2, at least MAX_BURST
LEN_WIDTH, 16, width of the beat-count field

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  transfer command valid
cmd_ready  out  1  high only in IDLE
cmd_addr  in  ADDR_WIDTH  start byte address; low log2(DATA_WIDTH/8) bits are forced to 0
cmd_beats  in  LEN_WIDTH  total beats; 0 is legal
m_axi_arid  out  ID_WIDTH  constant 0
m_axi_araddr  out  ADDR_WIDTH  burst address
m_axi_arlen  out  8  burst beats minus 1
m_axi_arsize  out  3  constant log2(DATA_WIDTH/8)
m_axi_arburst  out  2  constant 2'b01 (INCR)
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rid  in  ID_WIDTH  ignored
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_dat  out  DATA_WIDTH  stream data
m_idx  out  LEN_WIDTH  beat index within the transfer, starting at 0
m_last  out  1  final beat of the transfer
m_valid  out  1  stream valid
m_ready  in  1  stream ready
done  out  1  one-cycle pulse when the transfer completes
err  out  1  sticky flag: some rresp was not 2'b00 during this transfer; cleared on cmd accept

Behaviour:
- Reset values: cmd_ready=0 during reset, then 1 in IDLE. arvalid=0, rready=0, m_valid=0, done=0, err=0, all counters 0, FIFO empty.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: on cmd_valid&&cmd_ready, latch addr and remaining=cmd_beats, clear err and the beat index. Go to ISSUE if cmd_beats>0. If cmd_beats==0, pulse done on the next cycle and stay in IDLE.
  - ISSUE: arvalid is asserted when remaining>0 and outstanding<MAX_OUTSTANDING. Burst length len = min(remaining, MAX_BURST, (4096 - addr[11:0])/(DATA_WIDTH/8)).
  - AR stability: araddr, arlen and arvalid are registered and stay stable until arready. On handshake: addr+=len*bytes, remaining-=len, outstanding+=1. When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until outstanding==0, the FIFO is empty and the last beat has been consumed. Then pulse done and go to IDLE.
- outstanding decrements on rvalid&&rready&&rlast. If an AR handshake and a last-beat handshake occur in the same cycle, outstanding is unchanged.
- m_axi_rready = !fifo_full. Each accepted R beat is pushed; the FIFO write happens in the same cycle as the R handshake.
- Stream side: m_valid = !fifo_empty, first-word fall-through, pop on m_valid&&m_ready. m_idx counts popped beats. m_last is high when m_idx == total-1.
- err is set on any accepted beat with rresp != 0. Beats with an error response are still delivered; the transfer always runs to completion.
- Simultaneous FIFO push and pop when full: pop first, so rready stays 0 that cycle (registered full flag).
- Address wrap at 2^ADDR_WIDTH is not checked; commands must not wrap.
- Asynchronous reset mid-transfer returns to IDLE and clears all state. In-flight AXI responses after reset are the interconnect's responsibility.

Test Plan:
- DATA_WIDTH=256, MAX_BURST=16; cmd addr=0x1000, beats=40 -> three ARs: (0x1000,len 15), (0x1200,15), (0x1400,7); 40 stream beats, m_idx 0..39, m_last on beat 39, done one cycle after the last pop.
- 4 KB boundary: addr=0x1F80, beats=8 -> AR (0x1F80,arlen 3) then (0x2000,arlen 3); no burst crosses 0x2000.
- Outstanding limit: arready=1, slave delays all R data -> exactly 4 ARs issued, arvalid held low until the first rlast, then the 5th AR issues.
- Backpressure: m_ready=0 with FIFO_DEPTH=32 and a 40-beat transfer -> rready drops after 32 beats, no data lost; releasing m_ready delivers all 40 beats in order with correct m_idx.
- Error: rresp=2'b10 on beat 5 of a 16-beat transfer -> err rises after that beat, all 16 beats still delivered, done pulses, err stays 1 until the next cmd is accepted.
- cmd_beats=0 -> no AR issued, done pulses one cycle after accept. aresetn asserted mid-transfer -> all outputs return to reset values; a fresh command afterwards completes normally.
